// File: rtl/lsu_axi_gen_if.sv
// AXI4-Lite bundle between lsu_axi_gen (master) and memory (slave).
// The bundle carries the read-address, read-data, write-address, write-data and write-response channels.
interface lsu_axi_gen_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    localparam int STRB_W = DATA_W / 8;

    logic [ADDR_W-1:0] araddr;
    logic              arvalid;
    logic              arready;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        rresp;
    logic              rvalid;
    logic              rready;
    logic [ADDR_W-1:0] awaddr;
    logic              awvalid;
    logic              awready;
    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] wstrb;
    logic              wvalid;
    logic              wready;
    logic [1:0]        bresp;
    logic              bvalid;
    logic              bready;

    modport master (
        output araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
        input  arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
    );

    modport slave (
        input  araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
        output arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
    );
endinterface

// File: rtl/lsu_axi_gen.sv
// Load/store unit: one AXI4-Lite access per memory op, byte-lane alignment, load extraction, error reporting.
// Optional bus watchdog enabled by defining LSU_AXI_TIMEOUT_EN (parameter TIMEOUT_CYC).
module lsu_axi_gen #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int TAG_W  = 64
`ifdef LSU_AXI_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYC = 255
`endif
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_ren,
    input  logic              in_wen,
    input  logic              in_signed,
    input  logic [1:0]        in_size,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic [DATA_W-1:0] in_wdata,
    input  logic [TAG_W-1:0]  in_tag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_rdata,
    output logic [TAG_W-1:0]  out_tag,
    output logic [1:0]        out_err,
    lsu_axi_gen_if.master     axi,
    output logic              busy
);
    localparam int STRB_W = DATA_W / 8;
    localparam int OFF_W  = $clog2(STRB_W);

    typedef enum logic [2:0] {IDLE, RD_A, RD_D, WR_A, WR_B, DONE} state_t;
    typedef enum logic [1:0] {
        ERR_OK       = 2'd0,
        ERR_MISALIGN = 2'd1,
        ERR_BUS      = 2'd2,
        ERR_TIMEOUT  = 2'd3
    } err_t;

    state_t            state;
    logic [OFF_W-1:0]  off_q;
    logic [1:0]        size_q;
    logic              signed_q;

    logic [OFF_W-1:0]  in_off;
    logic              in_misaligned;
    logic [ADDR_W-1:0] in_line_addr;
    logic [STRB_W-1:0] in_strb;
    logic [DATA_W-1:0] rd_shifted;
    logic [DATA_W-1:0] rd_mask;
    logic [DATA_W-1:0] rd_value;
    logic              rd_sign;
    logic              tmo_hit;

    assign in_ready     = (state == IDLE);
    assign busy         = (state != IDLE);
    assign in_off       = in_addr[OFF_W-1:0];
    assign in_line_addr = {in_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};

    function automatic logic [STRB_W-1:0] size_mask(input logic [1:0] size);
        logic [7:0] m;
        case (size)
            2'd0:    m = 8'h01;
            2'd1:    m = 8'h03;
            2'd2:    m = 8'h0F;
            default: m = 8'hFF;
        endcase
        return m[STRB_W-1:0];
    endfunction

    assign in_strb = size_mask(in_size) << in_off;

    always_comb begin
        // NOTE: default assignment first, so no path through the block leaves the output unassigned and infers a latch.
        in_misaligned = 1'b0;
        case (in_size)
            2'd0:    in_misaligned = 1'b0;
            2'd1:    in_misaligned = in_addr[0];
            2'd2:    in_misaligned = |in_addr[1:0];
            default: in_misaligned = (DATA_W == 32) || (|in_addr[2:0]);
        endcase
    end

    // Load data: bring the addressed lane down to bit 0, keep the access width, then extend.
    assign rd_shifted = axi.rdata >> {off_q, 3'b000};

    always_comb begin
        rd_mask = '1;
        rd_sign = rd_shifted[DATA_W-1];
        case (size_q)
            2'd0: begin
                rd_mask = DATA_W'(8'hFF);
                rd_sign = rd_shifted[7];
            end
            2'd1: begin
                rd_mask = DATA_W'(16'hFFFF);
                rd_sign = rd_shifted[15];
            end
            2'd2: begin
                rd_mask = DATA_W'(32'hFFFF_FFFF);
                rd_sign = rd_shifted[31];
            end
            default: ;
        endcase
        rd_value = rd_shifted & rd_mask;
        if (signed_q && rd_sign) rd_value = rd_value | ~rd_mask;
    end

`ifdef LSU_AXI_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
    logic [TMO_W-1:0] tmo_cnt;
    logic             in_bus_state;

    assign in_bus_state = (state == RD_A) || (state == RD_D) || (state == WR_A) || (state == WR_B);
    assign tmo_hit      = in_bus_state && (tmo_cnt == TMO_W'(TIMEOUT_CYC));

    // Held at zero while idle, so every bus access starts counting from zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                       tmo_cnt <= '0;
        else if (!in_bus_state)           tmo_cnt <= '0;
        else if (!tmo_hit)                tmo_cnt <= tmo_cnt + 1'b1;
    end
`else
    assign tmo_hit = 1'b0;
`endif

    // NOTE: sequential state uses <= only, so every register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            off_q       <= '0;
            size_q      <= '0;
            signed_q    <= 1'b0;
            axi.araddr  <= '0;
            axi.arvalid <= 1'b0;
            axi.rready  <= 1'b0;
            axi.awaddr  <= '0;
            axi.awvalid <= 1'b0;
            axi.wdata   <= '0;
            axi.wstrb   <= '0;
            axi.wvalid  <= 1'b0;
            axi.bready  <= 1'b0;
            out_valid   <= 1'b0;
            out_rdata   <= '0;
            out_tag     <= '0;
            out_err     <= ERR_OK;
        end else if (tmo_hit) begin
            axi.arvalid <= 1'b0;
            axi.rready  <= 1'b0;
            axi.awvalid <= 1'b0;
            axi.wvalid  <= 1'b0;
            axi.bready  <= 1'b0;
            out_valid   <= 1'b1;
            out_err     <= ERR_TIMEOUT;
            state       <= DONE;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    out_tag   <= in_tag;
                    out_rdata <= '0;
                    out_err   <= ERR_OK;
                    off_q     <= in_off;
                    size_q    <= in_size;
                    signed_q  <= in_signed;
                    if (!(in_ren || in_wen)) begin
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else if (in_misaligned) begin
                        out_valid <= 1'b1;
                        out_err   <= ERR_MISALIGN;
                        state     <= DONE;
                    end else if (in_ren) begin
                        axi.araddr  <= in_line_addr;
                        axi.arvalid <= 1'b1;
                        state       <= RD_A;
                    end else begin
                        axi.awaddr  <= in_line_addr;
                        axi.awvalid <= 1'b1;
                        axi.wdata   <= in_wdata << {in_off, 3'b000};
                        axi.wstrb   <= in_strb;
                        axi.wvalid  <= 1'b1;
                        state       <= WR_A;
                    end
                end
                RD_A: if (axi.arready) begin
                    axi.arvalid <= 1'b0;
                    axi.rready  <= 1'b1;
                    state       <= RD_D;
                end
                RD_D: if (axi.rvalid) begin
                    axi.rready <= 1'b0;
                    out_rdata  <= rd_value;
                    if (axi.rresp != 2'b00) out_err <= ERR_BUS;
                    out_valid  <= 1'b1;
                    state      <= DONE;
                end
                WR_A: begin
                    // AW and W complete independently; leave only once both are done.
                    if (axi.awready) axi.awvalid <= 1'b0;
                    if (axi.wready)  axi.wvalid  <= 1'b0;
                    if ((!axi.awvalid || axi.awready) && (!axi.wvalid || axi.wready)) begin
                        axi.bready <= 1'b1;
                        state      <= WR_B;
                    end
                end
                WR_B: if (axi.bvalid) begin
                    axi.bready <= 1'b0;
                    if (axi.bresp != 2'b00) out_err <= ERR_BUS;
                    out_valid  <= 1'b1;
                    state      <= DONE;
                end
                DONE: if (out_ready) begin
                    out_valid <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_lsu_axi_gen.sv
// Self-checking bench for lsu_axi_gen: directed scenarios plus randomized traffic against a byte-lane reference model.
module tb_lsu_axi_gen;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int TAG_W  = 64;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid, in_ready, in_ren, in_wen, in_signed;
    logic [1:0]        in_size;
    logic [ADDR_W-1:0] in_addr;
    logic [DATA_W-1:0] in_wdata;
    logic [TAG_W-1:0]  in_tag;
    logic              out_valid, out_ready, busy;
    logic [DATA_W-1:0] out_rdata;
    logic [TAG_W-1:0]  out_tag;
    logic [1:0]        out_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    lsu_axi_gen_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    lsu_axi_gen #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_ren(in_ren), .in_wen(in_wen),
        .in_signed(in_signed), .in_size(in_size), .in_addr(in_addr), .in_wdata(in_wdata),
        .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready), .out_rdata(out_rdata),
        .out_tag(out_tag), .out_err(out_err), .axi(bus), .busy(busy)
    );

    typedef struct {
        bit        ren, wen, sgn;
        bit [1:0]  size;
        bit [31:0] addr, wdata, rdata;
        bit [63:0] tag;
        bit [1:0]  resp;
        int        ar_dly, r_dly, aw_dly, w_dly, b_dly, o_dly;
    } txn_t;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_slave();
        bus.arready = 0; bus.rvalid = 0; bus.rdata = '0; bus.rresp = '0;
        bus.awready = 0; bus.wready = 0; bus.bvalid = 0; bus.bresp = '0;
        out_ready = 0;
    endtask

    function automatic txn_t new_txn(input bit ren, input bit wen, input bit sgn, input bit [1:0] size,
                                     input bit [31:0] addr, input bit [31:0] wdata, input bit [31:0] rdata);
        txn_t t;
        t.ren = ren; t.wen = wen; t.sgn = sgn; t.size = size;
        t.addr = addr; t.wdata = wdata; t.rdata = rdata;
        t.tag = {$urandom, $urandom}; t.resp = 2'd0;
        t.ar_dly = 0; t.r_dly = 0; t.aw_dly = 0; t.w_dly = 0; t.b_dly = 0; t.o_dly = 0;
        return t;
    endfunction

    // Reference model: expected bus-side and result-side values from byte offsets and access widths.
    task automatic model(input txn_t t, output logic [31:0] e_rdata, output logic [1:0] e_err,
                         output bit e_rd, output bit e_wr, output logic [31:0] e_baddr,
                         output logic [31:0] e_wdata, output logic [3:0] e_wstrb);
        int     nb, off;
        bit     mem, mis;
        longint v, one;
        one = 1;
        nb  = 1 << t.size;
        off = int'(t.addr % 4);
        mem = t.ren || t.wen;
        mis = mem && (t.size == 2'd3 || (t.addr % nb) != 0);
        e_rd = mem && !mis && t.ren;
        e_wr = mem && !mis && !t.ren;
        e_baddr = t.addr - off;
        v = longint'(t.wdata) << (8 * off);
        e_wdata = v[31:0];
        v = ((one << nb) - 1) << off;
        e_wstrb = v[3:0];
        e_rdata = '0;
        if (e_rd) begin
            v = (longint'(t.rdata) >> (8 * off)) % (one << (8 * nb));
            if (t.sgn && v >= (one << (8 * nb - 1))) v = v - (one << (8 * nb));
            e_rdata = v[31:0];
        end
        e_err = mis ? 2'd1 : ((e_rd || e_wr) && t.resp != 0) ? 2'd2 : 2'd0;
    endtask

    // Issues one request, plays the AXI slave and the WBU, and checks every observable along the way.
    task automatic run_txn(input txn_t t, input string name);
        logic [31:0] e_rdata, e_baddr, e_wdata;
        logic [1:0]  e_err;
        logic [3:0]  e_wstrb;
        bit          e_rd, e_wr, done, seen;
        bit          ar_hs, aw_hs, w_hs, r_hs, b_hs, o_hs, ar_pend, aw_pend, w_pend;
        int          cyc, ar_c, aw_c, w_c, r_c, b_c, o_c, ar_n, aw_n, w_n, r_n, b_n;
        model(t, e_rdata, e_err, e_rd, e_wr, e_baddr, e_wdata, e_wstrb);
        {ar_c, aw_c, w_c, r_c, b_c, o_c, ar_n, aw_n, w_n, r_n, b_n} = '0;
        {done, seen, ar_hs, aw_hs, w_hs, ar_pend, aw_pend, w_pend} = '0;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL %s in_ready_at_issue got %b exp 1", name, in_ready); end
        in_valid = 1; in_ren = t.ren; in_wen = t.wen; in_signed = t.sgn; in_size = t.size;
        in_addr = t.addr; in_wdata = t.wdata; in_tag = t.tag;
        step();
        in_valid = 0; in_addr = $urandom; in_wdata = $urandom; in_tag = {$urandom, $urandom};
        in_size = 2'($urandom_range(0, 3)); in_signed = 1'($urandom_range(0, 1));
        cyc = 1;
        while (!done && cyc < 200) begin
            checks++;
            if ((ar_pend && !bus.arvalid) || (aw_pend && !bus.awvalid) || (w_pend && !bus.wvalid) ||
                (ar_hs && bus.arvalid) || (aw_hs && bus.awvalid) || (w_hs && bus.wvalid)) begin
                errors++;
                $display("FAIL %s valid_protocol cyc %0d got ar/aw/w %b%b%b", name, cyc, bus.arvalid, bus.awvalid, bus.wvalid);
            end
            if (bus.arvalid) begin
                checks++;
                if (!e_rd || bus.araddr !== e_baddr) begin errors++;
                    $display("FAIL %s araddr got %h exp %h (read expected %0d)", name, bus.araddr, e_baddr, e_rd); end
            end
            if (bus.awvalid) begin
                checks++;
                if (!e_wr || bus.awaddr !== e_baddr) begin errors++;
                    $display("FAIL %s awaddr got %h exp %h (write expected %0d)", name, bus.awaddr, e_baddr, e_wr); end
            end
            if (bus.wvalid) begin
                checks++;
                if (!e_wr || bus.wdata !== e_wdata || bus.wstrb !== e_wstrb) begin errors++;
                    $display("FAIL %s wdata/wstrb got %h/%b exp %h/%b", name, bus.wdata, bus.wstrb, e_wdata, e_wstrb); end
            end
            if (bus.rready || bus.bready) begin
                checks++;
                if ((bus.rready && (!e_rd || ar_n != 1)) || (bus.bready && (!e_wr || aw_n != 1 || w_n != 1))) begin
                    errors++;
                    $display("FAIL %s resp_ready got rready %b bready %b after ar %0d aw %0d w %0d", name, bus.rready, bus.bready, ar_n, aw_n, w_n);
                end
            end
            bus.arready = bus.arvalid && (ar_c >= t.ar_dly); if (bus.arvalid) ar_c++;
            bus.awready = bus.awvalid && (aw_c >= t.aw_dly); if (bus.awvalid) aw_c++;
            bus.wready  = bus.wvalid && (w_c >= t.w_dly);   if (bus.wvalid) w_c++;
            bus.rvalid  = bus.rready && (r_c >= t.r_dly);   if (bus.rready) r_c++;
            bus.rdata   = bus.rvalid ? t.rdata : $urandom;
            bus.rresp   = bus.rvalid ? t.resp : 2'd0;
            bus.bvalid  = bus.bready && (b_c >= t.b_dly);   if (bus.bready) b_c++;
            bus.bresp   = bus.bvalid ? t.resp : 2'd0;
            if (out_valid) begin
                if (!seen) begin
                    seen = 1;
                    if (!e_rd && !e_wr) begin
                        checks++;
                        if (cyc != 1) begin errors++; $display("FAIL %s latency got %0d exp 1", name, cyc); end
                    end
                end
                checks++;
                if (out_rdata !== e_rdata || out_err !== e_err || out_tag !== t.tag) begin errors++;
                    $display("FAIL %s result got rdata %h err %0d tag %h exp rdata %h err %0d tag %h",
                             name, out_rdata, out_err, out_tag, e_rdata, e_err, t.tag); end
                checks++;
                if (in_ready !== 1'b0 || busy !== 1'b1) begin errors++;
                    $display("FAIL %s done_flags got in_ready %b busy %b exp 0 1", name, in_ready, busy); end
                out_ready = (o_c >= t.o_dly); o_c++;
            end else begin
                out_ready = 1'($urandom_range(0, 1));
            end
            ar_hs = bus.arvalid && bus.arready; aw_hs = bus.awvalid && bus.awready;
            w_hs = bus.wvalid && bus.wready;    r_hs = bus.rready && bus.rvalid;
            b_hs = bus.bready && bus.bvalid;    o_hs = out_valid && out_ready;
            ar_pend = bus.arvalid && !bus.arready; aw_pend = bus.awvalid && !bus.awready;
            w_pend = bus.wvalid && !bus.wready;
            step();
            cyc++;
            ar_n += int'(ar_hs); aw_n += int'(aw_hs); w_n += int'(w_hs); r_n += int'(r_hs); b_n += int'(b_hs);
            if (o_hs) done = 1;
        end
        clear_slave();
        checks++;
        if (!done) begin errors++; $display("FAIL %s timeout got no out handshake in %0d cycles exp completion", name, cyc); end
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin errors++;
            $display("FAIL %s idle_after got out_valid %b in_ready %b busy %b exp 0 1 0", name, out_valid, in_ready, busy); end
        checks++;
        if (ar_n != int'(e_rd) || r_n != int'(e_rd) || aw_n != int'(e_wr) || w_n != int'(e_wr) || b_n != int'(e_wr)) begin
            errors++;
            $display("FAIL %s handshakes got ar %0d r %0d aw %0d w %0d b %0d exp rd %0d wr %0d", name, ar_n, r_n, aw_n, w_n, b_n, e_rd, e_wr);
        end
    endtask

    task automatic test_reset();
        rst_n = 0;
        in_valid = 1;
        step(); step();
        checks++;
        if ({bus.arvalid, bus.awvalid, bus.wvalid, bus.rready, bus.bready, out_valid, busy} !== 7'b0) begin errors++;
            $display("FAIL reset_flags got %b exp 0", {bus.arvalid, bus.awvalid, bus.wvalid, bus.rready, bus.bready, out_valid, busy}); end
        checks++;
        if (bus.araddr !== '0 || bus.awaddr !== '0 || bus.wdata !== '0 || bus.wstrb !== '0) begin errors++;
            $display("FAIL reset_bus got %h %h %h %b exp 0", bus.araddr, bus.awaddr, bus.wdata, bus.wstrb); end
        checks++;
        if (out_rdata !== '0 || out_tag !== '0 || out_err !== '0) begin errors++;
            $display("FAIL reset_out got %h %h %0d exp 0", out_rdata, out_tag, out_err); end
        in_valid = 0;
        rst_n = 1;
        step();
    endtask

    task automatic test_load_byte_signed();
        run_txn(new_txn(1, 0, 1, 2'd0, 32'h8000_0003, 32'h0, 32'h80FF_1234), "load_byte_signed");
        run_txn(new_txn(1, 0, 0, 2'd1, 32'h8000_0002, 32'h0, 32'h80FF_1234), "load_half_unsigned");
    endtask

    task automatic test_store_half();
        txn_t t;
        t = new_txn(0, 1, 0, 2'd1, 32'h8000_0002, 32'h0000_ABCD, 32'h0);
        t.b_dly = 2;
        run_txn(t, "store_half");
    endtask

    task automatic test_independent_hs();
        txn_t t;
        t = new_txn(0, 1, 0, 2'd2, 32'h8000_0010, 32'hDEAD_BEEF, 32'h0);
        t.w_dly = 0; t.aw_dly = 3; t.b_dly = 1;
        run_txn(t, "w_before_aw");
        t = new_txn(0, 1, 0, 2'd0, 32'h8000_0011, 32'h0000_005A, 32'h0);
        t.aw_dly = 0; t.w_dly = 2;
        run_txn(t, "aw_before_w");
    endtask

    task automatic test_misaligned();
        run_txn(new_txn(1, 0, 0, 2'd2, 32'h8000_0002, 32'h0, 32'h1111_2222), "misaligned_word_load");
        run_txn(new_txn(0, 1, 0, 2'd1, 32'h8000_0001, 32'h1234, 32'h0), "misaligned_half_store");
        run_txn(new_txn(1, 0, 0, 2'd3, 32'h8000_0000, 32'h0, 32'h0), "dword_on_32bit");
    endtask

    task automatic test_bus_error();
        txn_t t;
        t = new_txn(1, 0, 1, 2'd2, 32'h8000_0020, 32'h0, 32'hCAFE_F00D);
        t.resp = 2'd2; t.r_dly = 1; t.o_dly = 4;
        run_txn(t, "load_bus_error");
        t = new_txn(0, 1, 0, 2'd2, 32'h8000_0024, 32'h0BAD_0BAD, 32'h0);
        t.resp = 2'd3; t.o_dly = 2;
        run_txn(t, "store_bus_error");
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) begin
            run_txn(new_txn(0, 0, 0, 2'($urandom_range(0, 3)), $urandom, $urandom, $urandom), "back_to_back_pass");
            run_txn(new_txn(1, 0, 0, 2'd2, 32'h8000_0040 + 4 * i, 32'h0, $urandom), "back_to_back_load");
        end
    endtask

    task automatic test_random();
        txn_t      t;
        int        op, sz;
        bit [31:0] a;
        for (int i = 0; i < 40; i++) begin
            op = $urandom_range(0, 2);
            sz = $urandom_range(0, 3);
            a  = 32'h8000_0000 + $urandom_range(0, 255);
            if ($urandom_range(0, 3) != 0) a = a & ~((32'd1 << sz) - 1);
            t = new_txn(op == 0, op == 1, 1'($urandom_range(0, 1)), sz[1:0], a, $urandom, $urandom);
            t.resp   = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
            t.ar_dly = $urandom_range(0, 3); t.r_dly = $urandom_range(0, 3);
            t.aw_dly = $urandom_range(0, 3); t.w_dly = $urandom_range(0, 3);
            t.b_dly  = $urandom_range(0, 3); t.o_dly = $urandom_range(0, 3);
            run_txn(t, "random");
        end
    endtask

    task automatic test_reset_mid();
        int n;
        in_valid = 1; in_ren = 1; in_wen = 0; in_signed = 0; in_size = 2'd2;
        in_addr = 32'h8000_0050; in_tag = 64'h1;
        step();
        in_valid = 0;
        bus.arready = 1;
        step();
        bus.arready = 0;
        n = 0;
        while (bus.rready !== 1'b1 && n < 10) begin step(); n++; end
        checks++;
        if (bus.rready !== 1'b1) begin errors++; $display("FAIL reset_mid_reach_rd_d got rready %b exp 1", bus.rready); end
        step();
        #2 rst_n = 0;
        #1;
        checks++;
        if ({bus.arvalid, bus.rready, out_valid, busy} !== 4'b0) begin errors++;
            $display("FAIL reset_mid_async got ar/r/out/busy %b exp 0", {bus.arvalid, bus.rready, out_valid, busy}); end
        @(negedge clk) rst_n = 1;
        bus.rvalid = 1; bus.rresp = 2'd2;
        step();
        bus.rvalid = 0; bus.rresp = 2'd0;
        step();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || bus.rready !== 1'b0) begin errors++;
            $display("FAIL reset_mid_no_completion got out_valid %b in_ready %b rready %b exp 0 1 0", out_valid, in_ready, bus.rready); end
        run_txn(new_txn(0, 0, 0, 2'd0, 32'h8000_0001, 32'h0, 32'h0), "pass_after_reset");
    endtask

    initial begin
        rst_n = 0; in_valid = 0; in_ren = 0; in_wen = 0; in_signed = 0; in_size = '0;
        in_addr = '0; in_wdata = '0; in_tag = '0;
        clear_slave();
        test_reset();
        test_load_byte_signed();
        test_store_half();
        test_independent_hs();
        test_misaligned();
        test_bus_error();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/lsu_axi_gen.md
Name: lsu_axi_gen

Overview:
- Parametrised successor load/store unit between EXU and WBU; issues one AXI4-Lite transaction per memory instruction.
- Generalised bus width DATA_W and opaque passthrough tag.
- Adds: byte-lane alignment of store data and strobes; offset-based load extraction with sign extension; misalignment detection; independent AW/W handshakes; bus-error reporting.
- Exactly one access outstanding; non-memory ops pass through in one cycle.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, bus and register data width, 32 or 64; STRB_W = DATA_W/8, OFF_W = log2(STRB_W).
- TAG_W, 64, width of passthrough bundle (pc, rd, write-enables, etc.).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  EXU request valid.
- in_ready  out  1  LSU can accept a request.
- in_ren / in_wen  in  1  load / store; neither = passthrough.
- in_signed  in  1  sign-extend load.
- in_size  in  2  0=byte, 1=half, 2=word, 3=dword (DATA_W=64 only).
- in_addr  in  ADDR_W  effective address.
- in_wdata  in  DATA_W  store data, LSB-aligned.
- in_tag  in  TAG_W  passthrough bundle.
- out_valid  out  1  result valid.
- out_ready  in  1  WBU accepts.
- out_rdata  out  DATA_W  extracted load data; 0 for stores and passthrough.
- out_tag  out  TAG_W  captured tag.
- out_err  out  2  0=ok, 1=misaligned, 2=bus error (resp!=0).
- araddr, arvalid, arready, rdata, rresp, rvalid, rready: AXI-Lite read channels; araddr ADDR_W, rdata DATA_W, rresp 2.
- awaddr, awvalid, awready, wdata, wstrb, wvalid, wready, bresp, bvalid, bready: AXI-Lite write channels; wstrb STRB_W.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (rst_n low, async): state IDLE; all valids/readies, addresses, data, strobes, out_*, and busy = 0.
- in_ready = (state == IDLE). Request accepted on in_valid && in_ready; all inputs captured that edge.
- States: IDLE, RD_A, RD_D, WR_A, WR_B, DONE.
- Misalignment: addr[size-1:0] != 0, or size=3 with DATA_W=32.
  - Misaligned accept -> DONE with out_err=1; no bus transaction.
- IDLE transitions:
  - Aligned load -> RD_A, arvalid=1.
  - Aligned store -> WR_A, awvalid=wvalid=1.
  - Passthrough -> DONE.
- Bus address and alignment:
  - araddr/awaddr = addr with low OFF_W bits cleared.
  - wdata = in_wdata << (8*off).
  - wstrb = ((1<<(1<<size))-1) << off.
- RD_A: arvalid held until arready; then RD_D, arvalid=0.
- RD_D: rready=1 (0 in all other states). On rvalid:
  - capture (rdata >> 8*off), truncated to size, zero- or sign-extended per in_signed.
  - err = 2 if rresp != 0.
  - -> DONE.
- WR_A: awvalid and wvalid each drop independently on their own handshake, same cycle or either order. Leave to WR_B only when both have completed.
- WR_B: bready=1. On bvalid, err = 2 if bresp != 0; -> DONE.
- DONE: out_valid=1, outputs stable until out_ready; on handshake -> IDLE.
  - Earliest new accept is the cycle after the handshake (no same-cycle re-accept).
- Latency: accept-to-out_valid = 1 cycle for passthrough/misaligned; 2 + bus wait cycles for loads/stores.
- Address and data held constant while the corresponding valid is high (AXI rule).
- Async reset mid-transaction: abandons it immediately; all valids drop with no completion.

Optional Feature:
- Macro LSU_AXI_TIMEOUT_EN.
- When defined: parameter TIMEOUT_CYC (default 255). A counter clears on entry to RD_A/WR_A and increments each cycle in RD_A, RD_D, WR_A, WR_B.
  - On reaching TIMEOUT_CYC: deassert all AXI valids/readies, go to DONE with out_err=3.
  - Late responses are ignored: rready/bready stay 0 outside RD_D/WR_B.
- When undefined: no counter; LSU waits indefinitely; out_err never 3.

Test Plan:
- Load byte, signed: addr 0x80000003, rdata 0x80FF_1234 (DATA_W=32) -> araddr 0x80000000, out_rdata 0xFFFF_FF80, out_err 0.
- Store half: addr 0x80000002, wdata 0x0000_ABCD -> awaddr 0x80000000, wdata 0xABCD_0000, wstrb 4'b1100; out_valid after bvalid.
- Independent handshakes: wready 3 cycles before awready -> wvalid drops first, awvalid holds, single bready handshake, out_err 0.
- Misaligned word load at 0x80000002 -> no arvalid ever, out_valid next cycle, out_err 1.
- Bus error and backpressure: rresp=2, out_ready low 4 cycles -> out_err 2, out_tag/out_rdata stable, in_ready low until handshake.
- Reset during RD_D -> arvalid/rready/out_valid 0 asynchronously; a subsequent passthrough request completes with out_err 0.
